// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait-state latency, single-cycle response.
// Optional misalignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        stall
);

   localparam int unsigned DEPTH    = 1 << ADDR_W;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                lat_write_q, lat_write_d;
   logic                lat_err_q, lat_err_d;
   logic [ADDR_W-1:0]   lat_idx_q, lat_idx_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic [31:0]         mem [DEPTH];
   logic [ADDR_W-1:0]   req_idx;
   logic                accept;
   logic                misaligned;
   logic                mem_we;
   logic                unused_addr_bits;

   assign req_idx = req_addr[ADDR_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign misaligned = |req_addr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   // Upper address bits alias; low bits matter only with alignment checking.
   assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   assign accept = (state_q == IDLE) && req_valid;
   // Reset blocks the commit so a store presented during reset never lands.
   assign mem_we = accept && req_write && !misaligned && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (req_be[b]) begin
               mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lat_write_d = lat_write_q;
      lat_err_d   = lat_err_q;
      lat_idx_d   = lat_idx_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               lat_write_d = req_write;
               lat_err_d   = misaligned;
               lat_idx_d   = req_idx;
               cnt_d       = CNT_INIT;
               state_d     = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = lat_err_q;
               rsp_rdata_d = (lat_write_q || lat_err_q) ? '0 : mem[lat_idx_q];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         lat_write_q <= 1'b0;
         lat_err_q   <= 1'b0;
         lat_idx_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lat_write_q <= lat_write_d;
         lat_err_q   <= lat_err_d;
         lat_idx_q   <= lat_idx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign stall     = req_valid && !req_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: reset, vector table, multi-cycle sequences and
// randomized traffic against a word-array reference model.
module tb_dmem_responder;

   localparam int unsigned AW = 10;
   localparam int unsigned L  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr  = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be    = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        stall;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem_m [1 << AW];
   bit          known [1 << AW];

   dmem_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic bit mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
      return a[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int idx;
      if (mis(a)) return;
      idx = int'(a[AW+1:2]);
      for (int b = 0; b < 4; b++)
         if (be[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
      known[idx] = 1'b1;
   endtask

   // Presents a request at a falling edge; returns just after the accepting rising edge.
   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      @(posedge clk);
      #1;
   endtask

   // lat = number of falling edges after acceptance until rsp_valid is seen (-1 on timeout).
   task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
      lat = -1; rd = '0; er = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            lat = i; rd = rsp_rdata; er = rsp_err;
            break;
         end
      end
   endtask

   task automatic xact(input string name, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [31:0] exp_rd, input bit chk_rd,
                       input logic exp_er);
      int          lat;
      logic [31:0] rd;
      logic        er;
      drive(w, a, d, be);
      req_valid = 1'b0;
      wait_rsp(lat, rd, er);
      if (w) model_store(a, d, be);
      chk({name, "_latency"}, 32'(lat), 32'(L + 1));
      chk({name, "_err"}, {31'b0, er}, {31'b0, exp_er});
      if (chk_rd) chk({name, "_rdata"}, rd, exp_rd);
   endtask

   initial begin
      int          lat;
      logic [31:0] rd, a, d, exp_rd;
      logic [3:0]  be;
      logic        er, w, exp_er;
      logic [AW-1:0] idx;
      bit          seen, chk_rd;

      tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0};
      tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF};
      tbl[2]  = '{1'b1, 32'h0000_1010, 32'h0000_00AA, 4'h1, 32'h0};
      tbl[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA};
      tbl[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0};
      tbl[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA};
      tbl[6]  = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 4'hF, 32'h0};
      tbl[7]  = '{1'b0, 32'h0000_3FFC, 32'h0,         4'h0, 32'h1234_5678};
      tbl[8]  = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_0000, 4'hC, 32'h0};
      tbl[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'hA5A5_5678};
      tbl[10] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'hA, 32'h0};
      tbl[11] = '{1'b0, 32'h0000_4010, 32'h0,         4'h0, 32'h11AD_33AA};

      // Reset asserted mid-cycle takes effect without a clock edge.
      #3 rst = 1'b1;
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      req_valid = 1'b1;
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         xact($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].be, tbl[i].exp, 1'b1, 1'b0);

      // Back-pressure: a second load held on the bus while the first is outstanding.
      drive(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      req_addr = 32'h0000_0FFC;
      for (int i = 1; i <= L; i++) begin
         @(negedge clk);
         chk($sformatf("bp_stall%0d", i), {31'b0, stall}, 32'd1);
         chk($sformatf("bp_ready%0d", i), {31'b0, req_ready}, 32'd0);
      end
      @(negedge clk);
      chk("bp_rsp1_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp1_rdata", rsp_rdata, mem_m[4]);
      chk("bp_rsp1_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_rsp1_stall", {31'b0, stall}, 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_rsp(lat, rd, er);
      chk("bp_rsp2_latency", 32'(lat), 32'(L + 1));
      chk("bp_rsp2_rdata", rd, mem_m[1023]);

      // Reset one cycle after a load is accepted: the response must never appear.
      drive(1'b0, 32'h0000_0010, 32'h0, 4'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2 * L + 4; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      chk("midrst_no_rsp", {31'b0, seen}, 32'd0);

      // A store committed at its accept edge survives a reset that follows.
      drive(1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF);
      req_valid = 1'b0;
      #1 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_store(32'h0000_0014, 32'hCAFE_F00D, 4'hF);
      xact("rst_store_kept", 1'b0, 32'h0000_0014, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
      xact("mis_store", 1'b1, 32'h0000_0012, 32'h1122_3344, 4'hF, 32'h0, 1'b1, 1'b1);
      xact("mis_load_prior", 1'b0, 32'h0000_0010, 32'h0, 4'h0, mem_m[4], 1'b1, 1'b0);
      xact("mis_load", 1'b0, 32'h0000_0013, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
`else
      xact("lowbits_ignored", 1'b0, 32'h0000_0013, 32'h0, 4'h0, mem_m[4], 1'b1, 1'b0);
`endif

      for (int n = 0; n < 300; n++) begin
         w   = 1'($urandom_range(0, 1));
         idx = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'(1008 + $urandom_range(0, 15));
         a   = ($urandom & 32'hFFFF_F000) | {20'b0, idx, 2'b00};
`ifdef DMEM_ALIGN_CHECK_EN
         if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
`else
         a[1:0] = 2'($urandom_range(0, 3));
`endif
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         exp_er = mis(a);
         exp_rd = '0;
         chk_rd = 1'b1;
         if (!w && !exp_er) begin
            if (known[idx]) exp_rd = mem_m[idx];
            else chk_rd = 1'b0;
         end
         xact($sformatf("rnd%0d", n), w, a, d, be, exp_rd, chk_rd, exp_er);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
